// File: rtl/adc_trigger_timer.sv
// adc_trigger_timer: centre-aligned triangle carrier that issues one-cycle
// trig_out pulses to the ADC sequencer at selected carrier phases, with
// decimation, overrun counting and an Avalon-MM register interface.
module adc_trigger_timer #(
  parameter int CW   = 16,
  parameter int DECW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          MMS_read,
  input  logic          MMS_write,
  input  logic [2:0]    MMS_address,
  input  logic [31:0]   MMS_writedata,
  output logic [31:0]   MMS_readdata,
  input  logic          seq_busy,
  output logic          trig_out,
  output logic [CW-1:0] carrier_count,
  output logic          carrier_dir
);

  typedef enum logic [1:0] {
    MODE_BOTTOM  = 2'd0,
    MODE_TOP     = 2'd1,
    MODE_BOTH    = 2'd2,
    MODE_CMP_UP  = 2'd3
  } trig_mode_t;

  logic            en;
  trig_mode_t      mode;
  logic [CW-1:0]   period_live;
  logic [CW-1:0]   period_shadow;
  logic [CW-1:0]   cmp_val;
  logic [DECW-1:0] decim;
  logic [DECW-1:0] dec_ctr;
  logic [15:0]     overrun;

  logic          wr_ctrl, wr_period, wr_cmp, wr_decim, wr_overrun;
  logic          next_en;
  logic [CW-1:0] eff_period;
  logic          ev_bottom, ev_top, ev_cmp, qualify, candidate;
  logic          unused_inputs;

  // The read strobe and high write-data bits carry no information here.
  assign unused_inputs = ^{MMS_read, MMS_writedata};

  assign wr_ctrl    = MMS_write && (MMS_address == 3'd0);
  assign wr_period  = MMS_write && (MMS_address == 3'd1);
  assign wr_cmp     = MMS_write && (MMS_address == 3'd2);
  assign wr_decim   = MMS_write && (MMS_address == 3'd3);
  assign wr_overrun = MMS_write && (MMS_address == 3'd4);

  // EN as it will be after this edge; a disabling write suppresses a trigger in flight.
  assign next_en    = wr_ctrl ? MMS_writedata[0] : en;

  // A programmed peak of zero would stall the carrier, so it behaves as one.
  assign eff_period = (period_live == '0) ? CW'(1) : period_live;

  // Event detection on the registered carrier, then mode selection and decimation match.
  always_comb begin
    ev_bottom = en && (carrier_count == '0);
    ev_top    = en && carrier_dir && (carrier_count == eff_period);
    ev_cmp    = en && carrier_dir && (carrier_count == cmp_val) && (cmp_val <= eff_period);
    qualify   = 1'b0;
    case (mode)
      MODE_BOTTOM: qualify = ev_bottom;
      MODE_TOP:    qualify = ev_top;
      MODE_BOTH:   qualify = ev_bottom || ev_top;
      MODE_CMP_UP: qualify = ev_cmp;
      default:     qualify = 1'b0;
    endcase
    candidate = qualify && (dec_ctr == decim);
  end

  // Configuration registers, with the period shadow promoted at the carrier bottom.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en            <= 1'b0;
      mode          <= MODE_BOTTOM;
      period_live   <= CW'(1);
      period_shadow <= CW'(1);
      cmp_val       <= '0;
      decim         <= '0;
    end else begin
      if (wr_ctrl) begin
        en   <= MMS_writedata[0];
        mode <= trig_mode_t'(MMS_writedata[2:1]);
      end
      if (wr_period)
        period_shadow <= MMS_writedata[CW-1:0];
      if (wr_cmp)
        cmp_val <= MMS_writedata[CW-1:0];
      if (wr_decim)
        decim <= MMS_writedata[DECW-1:0];
      if (!en)
        period_live <= wr_period ? MMS_writedata[CW-1:0] : period_shadow;
      else if (carrier_count == '0)
        period_live <= period_shadow;
    end
  end

  // Triangle carrier: up to the peak, down to zero, folding back if the peak shrank below it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carrier_count <= '0;
      carrier_dir   <= 1'b1;
    end else if (!en) begin
      carrier_count <= '0;
      carrier_dir   <= 1'b1;
    end else if (carrier_count == '0) begin
      carrier_count <= CW'(1);
      carrier_dir   <= 1'b1;
    end else if (carrier_count >= eff_period) begin
      carrier_count <= carrier_count - CW'(1);
      carrier_dir   <= 1'b0;
    end else if (carrier_dir) begin
      carrier_count <= carrier_count + CW'(1);
    end else begin
      carrier_count <= carrier_count - CW'(1);
    end
  end

  // Decimation counter advances on every qualifying event and wraps when a candidate fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      dec_ctr <= '0;
    else if (!en || wr_decim)
      dec_ctr <= '0;
    else if (qualify)
      dec_ctr <= candidate ? '0 : dec_ctr + DECW'(1);
  end

  // Fire the trigger when the sequencer is idle, otherwise count a saturating overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_out <= 1'b0;
      overrun  <= '0;
    end else begin
      trig_out <= candidate && !seq_busy && next_en;
      if (wr_overrun)
        overrun <= '0;
      else if (candidate && seq_busy && (overrun != 16'hFFFF))
        overrun <= overrun + 16'd1;
    end
  end

  // Combinational register readback; unused bits and unmapped addresses read zero.
  always_comb begin
    MMS_readdata = '0;
    case (MMS_address)
      3'd0: MMS_readdata[2:0]      = {mode, en};
      3'd1: MMS_readdata[CW-1:0]   = period_shadow;
      3'd2: MMS_readdata[CW-1:0]   = cmp_val;
      3'd3: MMS_readdata[DECW-1:0] = decim;
      3'd4: MMS_readdata[15:0]     = overrun;
      3'd5: begin
        MMS_readdata[CW-1:0] = carrier_count;
        MMS_readdata[16]     = carrier_dir;
        MMS_readdata[17]     = en;
      end
      default: MMS_readdata = '0;
    endcase
  end

endmodule
